// File: rtl/multdiv_ctrl.sv
// Multi-cycle multiply/divide sequencer for the execute stage.
// Multiplies complete after a fixed latency. Divides use one radix-2
// restoring step per cycle. The result is returned as a HI/LO pair, or
// as a GPR value for MUL.
module multdiv_ctrl #(
  parameter int MULT_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic        req_is_mul,
  input  logic [4:0]  req_dest,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_hi,
  output logic [31:0] resp_lo,
  output logic        resp_hilo_write,
  output logic        resp_regwrite,
  output logic [4:0]  resp_dest
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        signed_q, signed_d;
  logic        is_mul_q, is_mul_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] resp_hi_q, resp_hi_d;
  logic [31:0] resp_lo_q, resp_lo_d;
  logic [4:0]  resp_dest_q, resp_dest_d;

  logic               accept;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [32:0] rem_sh;
  logic        [32:0] diff;
  logic               q_bit;
  logic        [31:0] rem_nx;
  logic        [31:0] dvd_nx;

  // Magnitude of a value, treated as two's complement only when sgn is set.
  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    return (sgn && v[31]) ? 32'(-v) : 32'(v);
  endfunction

  // Conditional two's-complement negation, used for the divide sign fixup.
  function automatic logic [31:0] neg_if(input logic signed [31:0] v, input logic neg);
    return neg ? 32'(-v) : 32'(v);
  endfunction

  assign accept = (state_q == S_IDLE) && req_valid && !flush;

  // Product and one restoring divide step, computed from the captured operands.
  always_comb begin
    prod_s = 64'(signed'(a_q)) * 64'(signed'(b_q));
    prod_u = 64'(a_q) * 64'(b_q);
    rem_sh = {rem_q, dvd_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    q_bit  = !diff[32];
    rem_nx = q_bit ? diff[31:0] : rem_sh[31:0];
    dvd_nx = {dvd_q[30:0], q_bit};
  end

  // Operand capture, counter and result registers.
  always_comb begin
    cnt_d       = cnt_q;
    signed_d    = signed_q;
    is_mul_d    = is_mul_q;
    dest_d      = dest_q;
    a_d         = a_q;
    b_d         = b_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    resp_hi_d   = resp_hi_q;
    resp_lo_d   = resp_lo_q;
    resp_dest_d = resp_dest_q;
    if (accept) begin
      signed_d = !req_type[0];
      is_mul_d = req_is_mul && (req_type == 2'd0);
      dest_d   = req_dest;
      a_d      = req_a;
      b_d      = req_b;
      dvd_d    = mag32(req_a, !req_type[0]);
      dvs_d    = mag32(req_b, !req_type[0]);
      rem_d    = '0;
      cnt_d    = req_type[1] ? 5'd31 : 5'(MULT_LAT - 1);
      // Divide by zero goes straight to DONE, so its result is set here.
      if (req_type[1] && (req_b == '0)) begin
        resp_hi_d   = req_a;
        resp_lo_d   = '1;
        resp_dest_d = req_dest;
      end
    end else if (!flush) begin
      case (state_q)
        S_MUL: begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == '0) begin
            resp_hi_d   = signed_q ? prod_s[63:32] : prod_u[63:32];
            resp_lo_d   = signed_q ? prod_s[31:0]  : prod_u[31:0];
            resp_dest_d = dest_q;
          end
        end
        S_DIV: begin
          cnt_d = cnt_q - 5'd1;
          dvd_d = dvd_nx;
          rem_d = rem_nx;
          if (cnt_q == '0) begin
            resp_lo_d   = neg_if(dvd_nx, signed_q && (a_q[31] ^ b_q[31]));
            resp_hi_d   = neg_if(rem_nx, signed_q && a_q[31]);
            resp_dest_d = dest_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State register and datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      signed_q    <= 1'b0;
      is_mul_q    <= 1'b0;
      dest_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      resp_hi_q   <= '0;
      resp_lo_q   <= '0;
      resp_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      signed_q    <= signed_d;
      is_mul_q    <= is_mul_d;
      dest_q      <= dest_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      resp_hi_q   <= resp_hi_d;
      resp_lo_q   <= resp_lo_d;
      resp_dest_q <= resp_dest_d;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          if (!req_type[1])        state_d = S_MUL;
          else if (req_b == '0)    state_d = S_DONE;
          else                     state_d = S_DIV;
        end
        S_MUL:  if (cnt_q == '0) state_d = S_DONE;
        S_DIV:  if (cnt_q == '0) state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake and result strobes; a flush suppresses the DONE strobes.
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    busy            = (state_q != S_IDLE);
    resp_valid      = (state_q == S_DONE) && !flush;
    resp_hilo_write = resp_valid && !is_mul_q;
    resp_regwrite   = resp_valid && is_mul_q;
  end

  assign resp_hi   = resp_hi_q;
  assign resp_lo   = resp_lo_q;
  assign resp_dest = resp_dest_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: directed operations push expected
// results; a monitor pops and compares whenever resp_valid is seen.
module tb_multdiv_ctrl;
  localparam int MULT_LAT = 4;
  localparam int LAT_MUL  = MULT_LAT + 1;
  localparam int LAT_DIV  = 33;
  localparam int LAT_DZ   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic        req_is_mul;
  logic [4:0]  req_dest;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_hi;
  logic [31:0] resp_lo;
  logic        resp_hilo_write;
  logic        resp_regwrite;
  logic [4:0]  resp_dest;

  multdiv_ctrl #(.MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_is_mul(req_is_mul), .req_dest(req_dest),
    .req_a(req_a), .req_b(req_b), .flush(flush), .busy(busy),
    .resp_valid(resp_valid), .resp_hi(resp_hi), .resp_lo(resp_lo),
    .resp_hilo_write(resp_hilo_write), .resp_regwrite(resp_regwrite),
    .resp_dest(resp_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo;
    logic        regw;
    logic [4:0]  dest;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every response strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        chk("resp_hi", 64'(resp_hi), 64'(e.hi));
        chk("resp_lo", 64'(resp_lo), 64'(e.lo));
        chk("resp_hilo_write", 64'(resp_hilo_write), 64'(e.hilo));
        chk("resp_regwrite", 64'(resp_regwrite), 64'(e.regw));
        if (e.regw) chk("resp_dest", 64'(resp_dest), 64'(e.dest));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single cycle once the block is ready.
  task automatic issue(input logic [1:0] t, input logic ism, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    req_valid  = 1'b1;
    req_type   = t;
    req_is_mul = ism;
    req_dest   = d;
    req_a      = a;
    req_b      = b;
  endtask

  // Issue an operation, queue its expected result and wait for it to drain.
  task automatic run(input string name, input logic [1:0] t, input logic ism,
                     input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic ehilo, input logic eregw, input int lat);
    exp_t e;
    int n = 0;
    issue(t, ism, d, a, b);
    e.hi = ehi; e.lo = elo; e.hilo = ehilo; e.regw = eregw; e.dest = d;
    e.cyc = cyc + lat;
    sb.push_back(e);
    step();
    req_valid = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'd1);
    chk({name, "_not_ready"}, 64'(req_ready), 64'd0);
    while (sb.size() != 0 && n < 80) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    sb.delete();
    chk({name, "_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_type = '0; req_is_mul = 1'b0;
    req_dest = '0; req_a = '0; req_b = '0; flush = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_hi", 64'(resp_hi), 64'd0);
    chk("rst_lo", 64'(resp_lo), 64'd0);
    chk("rst_dest", 64'(resp_dest), 64'd0);

    run("mult_neg", 2'd0, 1'b0, 5'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1'b0, LAT_MUL);
    run("mult_negneg", 2'd0, 1'b0, 5'd0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0, 32'd15, 1'b1, 1'b0, LAT_MUL);
    run("multu_max", 2'd1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 1'b1, 1'b0, LAT_MUL);
    run("mul_gpr", 2'd0, 1'b1, 5'd9, 32'd7, 32'd6, 32'h0, 32'd42, 1'b0, 1'b1, LAT_MUL);
    run("multu_ismul_ignored", 2'd1, 1'b1, 5'd3, 32'd5, 32'd4, 32'h0, 32'd20, 1'b1, 1'b0, LAT_MUL);
    run("div_neg7_2", 2'd2, 1'b0, 5'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b0, LAT_DIV);
    run("div_7_neg2", 2'd2, 1'b0, 5'd0, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b1, 1'b0, LAT_DIV);
    run("divu_100_7", 2'd3, 1'b0, 5'd0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 1'b0, LAT_DIV);
    run("div_min_neg1", 2'd2, 1'b0, 5'd0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b1, 1'b0, LAT_DIV);
    run("divu_big", 2'd3, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 1'b1, 1'b0, LAT_DIV);
    run("divu_by0", 2'd3, 1'b0, 5'd0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0, LAT_DZ);
    run("div_by0", 2'd2, 1'b0, 5'd0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0, LAT_DZ);

    // Flush in the middle of a divide: idle next cycle, no response.
    issue(2'd2, 1'b0, 5'd0, 32'd1000, 32'd3);
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_div_ready", 64'(req_ready), 64'd1);
    chk("flush_div_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 40; i++) step();

    // Flush coinciding with the DONE cycle of a divide-by-zero.
    issue(2'd3, 1'b0, 5'd0, 32'd5, 32'd0);
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_done_valid", 64'(resp_valid), 64'd0);
    chk("flush_done_hilo", 64'(resp_hilo_write), 64'd0);
    chk("flush_done_regw", 64'(resp_regwrite), 64'd0);
    step();
    flush = 1'b0;
    chk("flush_done_ready", 64'(req_ready), 64'd1);

    // Request together with flush in IDLE is dropped.
    req_valid = 1'b1; req_type = 2'd0; req_is_mul = 1'b0; req_a = 32'd2; req_b = 32'd2;
    flush = 1'b1;
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    chk("flush_idle_busy", 64'(busy), 64'd0);
    chk("flush_idle_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 10; i++) step();

    // Reset in the middle of a divide.
    issue(2'd2, 1'b0, 5'd0, 32'd1000, 32'd3);
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_div_busy", 64'(busy), 64'd0);
    chk("rst_div_ready", 64'(req_ready), 64'd1);
    chk("rst_div_valid", 64'(resp_valid), 64'd0);
    chk("rst_div_hi", 64'(resp_hi), 64'd0);
    chk("rst_div_lo", 64'(resp_lo), 64'd0);
    run("mult_after_rst", 2'd0, 1'b0, 5'd0, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b1, 1'b0, LAT_MUL);

    for (int i = 0; i < 5; i++) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
